riscv_coredpathbypassscoreboard: RTL and testbench

//  Parametrised bypass/interlock unit for the 5-stage core. Shadows dest-reg state of
//  in-flight instrs in stages X..W, drives per-read-port operand source selects for

---
 rtl/riscv_coredpathbypassscoreboard.sv | 110 +++++++++++
 tb/tb_riscv_coredpathbypassscoreboard.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_coredpathbypassscoreboard.sv
// Bypass/interlock scoreboard for the 5-stage core: shadows destination state of
// in-flight instructions in X..W, drives operand source selects and the RAW interlock.
module riscv_coredpathbypassscoreboard #(
  parameter int unsigned NUM_READ = 2,
  parameter int unsigned NUM_STG  = 3,
  parameter int unsigned LOAD_RDY = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_val_Dhl,
  input  logic                    issue_wen_Dhl,
  input  logic [4:0]              issue_waddr_Dhl,
  input  logic [1:0]              issue_kind_Dhl,
  input  logic [NUM_READ-1:0]     rs_used_Dhl,
  input  logic [5*NUM_READ-1:0]   rs_addr_Dhl,
  input  logic                    ext_stall_Dhl,
  input  logic                    squash_Dhl,
  input  logic [NUM_STG-1:0]      stall_stg,
  input  logic                    muldivresp_val,
  input  logic                    cnt_clr,
  output logic [3*NUM_READ-1:0]   rs_src_Dhl,
  output logic                    raw_stall_Dhl,
  output logic [CNT_W-1:0]        raw_stall_cnt
);

  typedef enum logic [1:0] {
    KIND_ALU    = 2'd0,
    KIND_LOAD   = 2'd1,
    KIND_MULDIV = 2'd2,
    KIND_RSVD   = 2'd3
  } kind_e;

  logic [NUM_STG:1]    stg_val;
  logic [NUM_STG:1]    stg_wen;
  logic [NUM_STG:1]    stg_rdy;
  logic [4:0]          stg_waddr [1:NUM_STG];
  kind_e               stg_kind  [1:NUM_STG];
  logic [NUM_READ-1:0] port_stall;
  logic                fire;

  // Result availability per stage for the producer currently shadowed there.
  always_comb begin
    stg_rdy = '0;
    for (int unsigned k = 1; k <= NUM_STG; k++) begin
      case (stg_kind[k])
        KIND_LOAD:   stg_rdy[k] = stg_val[k] && stg_wen[k] && (k >= LOAD_RDY);
        KIND_MULDIV: stg_rdy[k] = stg_val[k] && stg_wen[k] && ((k > 1) || muldivresp_val);
        default:     stg_rdy[k] = stg_val[k] && stg_wen[k];
      endcase
    end
  end

  // Scan oldest to youngest so the youngest matching producer overrides older ones.
  always_comb begin
    rs_src_Dhl = '0;
    port_stall = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      if (rs_used_Dhl[i] && (rs_addr_Dhl[5*i +: 5] != 5'd0)) begin
        for (int unsigned k = NUM_STG; k >= 1; k--) begin
          if (stg_val[k] && stg_wen[k] && (stg_waddr[k] == rs_addr_Dhl[5*i +: 5])) begin
            rs_src_Dhl[3*i +: 3] = stg_rdy[k] ? 3'(k) : 3'd0;
            port_stall[i]        = ~stg_rdy[k];
          end
        end
      end
    end
  end

  assign raw_stall_Dhl = issue_val_Dhl & (|port_stall);
  assign fire = issue_val_Dhl & ~raw_stall_Dhl & ~ext_stall_Dhl & ~squash_Dhl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_val <= '0;
      stg_wen <= '0;
      for (int unsigned k = 1; k <= NUM_STG; k++) begin
        stg_waddr[k] <= '0;
        stg_kind[k]  <= KIND_ALU;
      end
    end else begin
      if (!stall_stg[0]) begin
        stg_val[1]   <= fire;
        stg_wen[1]   <= issue_wen_Dhl;
        stg_waddr[1] <= issue_waddr_Dhl;
        stg_kind[1]  <= kind_e'(issue_kind_Dhl);
      end
      // A held upstream stage leaves a bubble behind in the stage it would feed.
      for (int unsigned k = 2; k <= NUM_STG; k++) begin
        if (!stall_stg[k-1]) begin
          stg_val[k]   <= stall_stg[k-2] ? 1'b0 : stg_val[k-1];
          stg_wen[k]   <= stg_wen[k-1];
          stg_waddr[k] <= stg_waddr[k-1];
          stg_kind[k]  <= stg_kind[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_stall_cnt <= '0;
    end else if (cnt_clr) begin
      raw_stall_cnt <= '0;
    end else if (issue_val_Dhl && raw_stall_Dhl && (raw_stall_cnt != '1)) begin
      raw_stall_cnt <= raw_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_coredpathbypassscoreboard.sv
// Bench for the bypass scoreboard: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_riscv_coredpathbypassscoreboard;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_val_Dhl, issue_wen_Dhl;
  logic [4:0]    issue_waddr_Dhl;
  logic [1:0]    issue_kind_Dhl;
  logic [1:0]    rs_used_Dhl;
  logic [9:0]    rs_addr_Dhl;
  logic          ext_stall_Dhl, squash_Dhl;
  logic [2:0]    stall_stg;
  logic          muldivresp_val, cnt_clr;
  logic [5:0]    rs_src_Dhl;
  logic          raw_stall_Dhl;
  logic [CW-1:0] raw_stall_cnt;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 0;

  riscv_coredpathbypassscoreboard #(
    .NUM_READ(2), .NUM_STG(3), .LOAD_RDY(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_val_Dhl(issue_val_Dhl), .issue_wen_Dhl(issue_wen_Dhl),
    .issue_waddr_Dhl(issue_waddr_Dhl), .issue_kind_Dhl(issue_kind_Dhl),
    .rs_used_Dhl(rs_used_Dhl), .rs_addr_Dhl(rs_addr_Dhl),
    .ext_stall_Dhl(ext_stall_Dhl), .squash_Dhl(squash_Dhl),
    .stall_stg(stall_stg), .muldivresp_val(muldivresp_val), .cnt_clr(cnt_clr),
    .rs_src_Dhl(rs_src_Dhl), .raw_stall_Dhl(raw_stall_Dhl), .raw_stall_cnt(raw_stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed { bit val; bit wen; bit [4:0] waddr; bit [1:0] kind; } ent_t;
  ent_t pipe [1:3];
  int   m_cnt;

  function automatic bit m_ready(input int k, input ent_t e);
    if (e.kind == 2'd1) return k >= 2;
    if (e.kind == 2'd2) return (k > 1) || muldivresp_val;
    return 1'b1;
  endfunction

  // First (youngest) matching stage decides the port outcome.
  function automatic void m_port(input int i, output int src, output bit stl);
    logic [4:0] a;
    bit found;
    a = rs_addr_Dhl[5*i +: 5];
    src = 0; stl = 0; found = 0;
    if (rs_used_Dhl[i] && a != 5'd0) begin
      for (int k = 1; k <= 3; k++) begin
        if (!found && pipe[k].val && pipe[k].wen && pipe[k].waddr == a) begin
          found = 1;
          if (m_ready(k, pipe[k])) src = k; else stl = 1;
        end
      end
    end
  endfunction

  function automatic bit m_stall();
    int s0, s1;
    bit t0, t1;
    m_port(0, s0, t0);
    m_port(1, s1, t1);
    return issue_val_Dhl && (t0 || t1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= 3; k++) pipe[k] = '0;
      m_cnt = 0;
    end else begin
      ent_t old [1:3];
      bit st, fire;
      old  = pipe;
      st   = m_stall();
      fire = issue_val_Dhl && !st && !ext_stall_Dhl && !squash_Dhl;
      if (!stall_stg[0])
        pipe[1] = fire ? ent_t'{1'b1, issue_wen_Dhl, issue_waddr_Dhl, issue_kind_Dhl} : '0;
      for (int k = 2; k <= 3; k++)
        if (!stall_stg[k-1]) pipe[k] = stall_stg[k-2] ? '0 : old[k-1];
      if (cnt_clr) m_cnt = 0;
      else if (st && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (run_cmp && !reset) begin
      int s0, s1;
      bit t0, t1;
      m_port(0, s0, t0);
      m_port(1, s1, t1);
      chk("model_src0", 32'(rs_src_Dhl[2:0]), 32'(s0));
      chk("model_src1", 32'(rs_src_Dhl[5:3]), 32'(s1));
      chk("model_stall", 32'(raw_stall_Dhl), 32'(m_stall()));
      chk("model_cnt", 32'(raw_stall_cnt), 32'(m_cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    issue_val_Dhl = 0; issue_wen_Dhl = 0; issue_waddr_Dhl = 0; issue_kind_Dhl = 0;
    rs_used_Dhl = 0; rs_addr_Dhl = 0; ext_stall_Dhl = 0; squash_Dhl = 0;
    stall_stg = 0; muldivresp_val = 0; cnt_clr = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] kind);
    idle();
    issue_val_Dhl = 1; issue_wen_Dhl = 1; issue_waddr_Dhl = rd; issue_kind_Dhl = kind;
  endtask

  task automatic read(input logic v, input logic [1:0] used, input logic [4:0] a0, input logic [4:0] a1);
    idle();
    issue_val_Dhl = v; rs_used_Dhl = used; rs_addr_Dhl = {a1, a0};
  endtask

  initial begin
    idle();
    reset = 1;
    #12;
    reset = 0;
    run_cmp = 1;
    step();
    settle();
    chk("reset_src", 32'(rs_src_Dhl), 0);
    chk("reset_stall", 32'(raw_stall_Dhl), 0);
    chk("reset_cnt", 32'(raw_stall_cnt), 0);

    // 1: ALU x5 bypassed from X, M, W, then register file
    issue(5, 0); step();
    read(1, 2'b01, 5, 0); settle();
    chk("t1_src_x", 32'(rs_src_Dhl[2:0]), 1);
    chk("t1_nostall", 32'(raw_stall_Dhl), 0);
    step(); read(0, 2'b01, 5, 0); settle();
    chk("t1_src_m", 32'(rs_src_Dhl[2:0]), 2);
    step(); settle();
    chk("t1_src_w", 32'(rs_src_Dhl[2:0]), 3);
    step(); settle();
    chk("t1_src_rf", 32'(rs_src_Dhl[2:0]), 0);

    // 2: load-use interlock for one cycle
    issue(6, 1); step();
    read(1, 2'b10, 0, 6); settle();
    chk("t2_stall", 32'(raw_stall_Dhl), 1);
    chk("t2_src_stall", 32'(rs_src_Dhl[5:3]), 0);
    step(); settle();
    chk("t2_cnt", 32'(raw_stall_cnt), 1);
    chk("t2_nostall", 32'(raw_stall_Dhl), 0);
    chk("t2_src_m", 32'(rs_src_Dhl[5:3]), 2);

    // 3: muldiv iterating in X for four cycles
    idle(); step();
    issue(7, 2); step();
    for (int c = 1; c <= 4; c++) begin
      read(1, 2'b01, 7, 0);
      stall_stg = 3'b001; ext_stall_Dhl = 1; muldivresp_val = (c == 4);
      settle();
      if (c < 4) chk("t3_stall", 32'(raw_stall_Dhl), 1);
      else begin
        chk("t3_resp_stall", 32'(raw_stall_Dhl), 0);
        chk("t3_resp_src", 32'(rs_src_Dhl[2:0]), 1);
        chk("t3_cnt", 32'(raw_stall_cnt), 4);
      end
      step();
    end
    idle(); step(); step(); step(); step();

    // 4: youngest producer wins; x0 never bypasses
    issue(5, 1); step();
    issue(5, 0); step();
    read(0, 2'b11, 5, 0); settle();
    chk("t4_youngest", 32'(rs_src_Dhl[2:0]), 1);
    chk("t4_x0_port1", 32'(rs_src_Dhl[5:3]), 0);
    issue(0, 0); step();
    read(1, 2'b01, 0, 0); settle();
    chk("t4_x0_match", 32'(rs_src_Dhl[2:0]), 0);
    chk("t4_x0_stall", 32'(raw_stall_Dhl), 0);
    idle(); step(); step(); step();

    // 5: squashed instruction leaves a bubble
    issue(9, 0); squash_Dhl = 1; step();
    read(0, 2'b01, 9, 0); settle();
    chk("t5_squash_x", 32'(rs_src_Dhl[2:0]), 0);
    step(); settle();
    chk("t5_squash_m", 32'(rs_src_Dhl[2:0]), 0);
    idle(); step(); step(); step();

    // 6: async reset during a muldiv stall, then counter saturation and clear
    issue(7, 2); step();
    read(1, 2'b01, 7, 0); stall_stg = 3'b001; ext_stall_Dhl = 1;
    step(); step(); settle();
    chk("t6_pre_stall", 32'(raw_stall_Dhl), 1);
    reset = 1; #1;
    chk("t6_rst_stall", 32'(raw_stall_Dhl), 0);
    chk("t6_rst_src", 32'(rs_src_Dhl), 0);
    chk("t6_rst_cnt", 32'(raw_stall_cnt), 0);
    step(); reset = 0;
    idle(); issue(6, 1); step();
    read(1, 2'b01, 6, 0); stall_stg = 3'b001;
    for (int c = 0; c < 20; c++) step();
    settle();
    chk("t6_sat", 32'(raw_stall_cnt), (1 << CW) - 1);
    chk("t6_sat_stall", 32'(raw_stall_Dhl), 1);
    cnt_clr = 1; step(); cnt_clr = 0; settle();
    chk("t6_clr", 32'(raw_stall_cnt), 0);
    step(); settle();
    chk("t6_after_clr", 32'(raw_stall_cnt), 1);

    // Randomized traffic
    idle(); step();
    for (int c = 0; c < 3000; c++) begin
      issue_val_Dhl   = ($urandom_range(0, 3) != 0);
      issue_wen_Dhl   = ($urandom_range(0, 3) != 0);
      issue_waddr_Dhl = 5'($urandom_range(0, 7));
      issue_kind_Dhl  = 2'($urandom_range(0, 3));
      rs_used_Dhl     = 2'($urandom_range(0, 3));
      rs_addr_Dhl     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ext_stall_Dhl   = ($urandom_range(0, 7) == 0);
      squash_Dhl      = ($urandom_range(0, 7) == 0);
      stall_stg       = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                         ($urandom_range(0, 2) == 0)};
      muldivresp_val  = ($urandom_range(0, 2) == 0);
      cnt_clr         = ($urandom_range(0, 63) == 0);
      step();
    end

    idle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
